// File: rtl/sva_stim_player_if.sv
// rtl/sva_stim_player_if.sv - control/RAM-load/stimulus bundle for sva_stim_player (optional LFSR ports under SVA_STIM_LFSR_EN)
interface sva_stim_player_if #(
  parameter int SIG_W  = 3,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH),
  parameter int LOOP_W = 8
);
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [SIG_W-1:0]  wr_data;
  logic              start;
  logic [AW:0]       len;
  logic [LOOP_W-1:0] loops;
  logic              pause;
  logic              stop;
`ifdef SVA_STIM_LFSR_EN
  logic              lfsr_mode;
  logic [15:0]       seed;
`endif
  logic [SIG_W-1:0]  sig;
  logic              sig_valid;
  logic              busy;
  logic              done;
  logic              cfg_err;
  logic [LOOP_W-1:0] loop_cnt;

  // Bench / controller side
  modport master (
    output wr_en, wr_addr, wr_data, start, len, loops, pause, stop,
`ifdef SVA_STIM_LFSR_EN
    output lfsr_mode, seed,
`endif
    input  sig, sig_valid, busy, done, cfg_err, loop_cnt
  );

  // Player side
  modport slave (
    input  wr_en, wr_addr, wr_data, start, len, loops, pause, stop,
`ifdef SVA_STIM_LFSR_EN
    input  lfsr_mode, seed,
`endif
    output sig, sig_valid, busy, done, cfg_err, loop_cnt
  );
endinterface

// File: rtl/sva_stim_player.sv
// rtl/sva_stim_player.sv - pattern-RAM stimulus player for SVA checker inputs (optional LFSR scrambling under SVA_STIM_LFSR_EN)
module sva_stim_player #(
  parameter int SIG_W  = 3,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH),
  parameter int LOOP_W = 8
) (
  input  logic             gclk,
  input  logic             grst,
  sva_stim_player_if.slave bus
);

  localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_PAUSED} state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [SIG_W-1:0]  r_mem [DEPTH];
  logic [AW-1:0]     r_rd_ptr;
  logic [AW-1:0]     r_last_ptr;
  logic [LOOP_W-1:0] r_loops;
  logic [LOOP_W-1:0] r_loop_cnt;
  logic              r_fin;
  logic [SIG_W-1:0]  r_sig;
  logic              r_sig_valid;
  logic              r_done;
  logic              r_cfg_err;

  logic              w_busy;
  logic              w_cfg_bad;
  logic              w_launch;
  logic              w_issue;
  logic              w_wrap;
  logic              w_last;
  logic [LOOP_W-1:0] w_cnt_inc;
  logic [SIG_W-1:0]  w_vec;

`ifdef SVA_STIM_LFSR_EN
  logic [15:0]       r_lfsr;
  logic              r_lfsr_mode;
  logic              w_lfsr_fb;

  // Fibonacci taps 16,14,13,11 in right-shift form
  assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
  assign w_vec     = r_mem[r_rd_ptr] ^ (r_lfsr_mode ? r_lfsr[SIG_W-1:0] : '0);

  // LFSR seeds at launch and steps only when a vector is actually issued
  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      r_lfsr      <= 16'hACE1;
      r_lfsr_mode <= 1'b0;
    end else if (w_launch) begin
      r_lfsr      <= (bus.seed == 16'h0000) ? 16'hACE1 : bus.seed;
      r_lfsr_mode <= bus.lfsr_mode;
    end else if (w_issue) begin
      r_lfsr      <= {w_lfsr_fb, r_lfsr[15:1]};
    end
  end
`else
  assign w_vec = r_mem[r_rd_ptr];
`endif

  // Pattern RAM write port; out-of-range addresses only exist for non-power-of-2 depths
  generate
    if (DEPTH == (1 << AW)) begin : g_wr_pow2
      always_ff @(posedge gclk) begin
        if (bus.wr_en) r_mem[bus.wr_addr] <= bus.wr_data;
      end
    end else begin : g_wr_npow2
      always_ff @(posedge gclk) begin
        if (bus.wr_en && (int'(bus.wr_addr) < DEPTH)) r_mem[bus.wr_addr] <= bus.wr_data;
      end
    end
  endgenerate

  // State register
  always_ff @(posedge gclk or posedge grst) begin
    if (grst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state: stop beats completion beats pause
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_launch) w_state_nxt = S_PLAY;
      end
      S_PLAY, S_PAUSED: begin
        if (bus.stop || r_fin) w_state_nxt = S_IDLE;
        else if (bus.pause)    w_state_nxt = S_PAUSED;
        else                   w_state_nxt = S_PLAY;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Per-cycle control decodes; a vector is issued on any active, unpaused, non-final cycle
  always_comb begin
    w_busy    = (r_state != S_IDLE);
    w_cfg_bad = (bus.len == '0) || (bus.len > L_DEPTH);
    w_launch  = (r_state == S_IDLE) && bus.start && !w_cfg_bad;
    w_issue   = w_busy && !bus.stop && !r_fin && !bus.pause;
    w_wrap    = (r_rd_ptr == r_last_ptr);
    w_cnt_inc = r_loop_cnt + 1'b1;
    w_last    = w_issue && w_wrap && (r_loops != '0) && (w_cnt_inc == r_loops);
  end

  // Playback datapath: read pointer, loop counter and registered stimulus outputs
  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      r_rd_ptr    <= '0;
      r_last_ptr  <= '0;
      r_loops     <= '0;
      r_loop_cnt  <= '0;
      r_fin       <= 1'b0;
      r_sig       <= '0;
      r_sig_valid <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_cfg_err   <= (r_state == S_IDLE) && bus.start && w_cfg_bad;
      r_done      <= w_busy && !bus.stop && r_fin;
      r_sig_valid <= w_issue;
      r_fin       <= w_last;
      if (w_launch) begin
        r_last_ptr <= AW'(bus.len - 1'b1);
        r_loops    <= bus.loops;
        r_rd_ptr   <= '0;
        r_loop_cnt <= '0;
      end
      if (w_issue) begin
        r_sig <= w_vec;
        if (w_wrap) begin
          r_rd_ptr   <= '0;
          r_loop_cnt <= w_cnt_inc;
        end else begin
          r_rd_ptr   <= r_rd_ptr + 1'b1;
        end
      end else if (w_busy && (w_state_nxt == S_IDLE)) begin
        r_sig <= '0;
      end
    end
  end

  assign bus.sig       = r_sig;
  assign bus.sig_valid = r_sig_valid;
  assign bus.busy      = w_busy;
  assign bus.done      = r_done;
  assign bus.cfg_err   = r_cfg_err;
  assign bus.loop_cnt  = r_loop_cnt;

endmodule

// File: tb/tb_sva_stim_player.sv
// tb/tb_sva_stim_player.sv - directed self-checking bench for sva_stim_player (LFSR steps under SVA_STIM_LFSR_EN)
module tb_sva_stim_player;

  logic gclk;
  logic grst;
  int   n_checks;
  int   n_errors;

  sva_stim_player_if #(.SIG_W(3), .DEPTH(16), .LOOP_W(8)) bus_if ();

  sva_stim_player #(.SIG_W(3), .DEPTH(16), .LOOP_W(8)) dut (
    .gclk (gclk),
    .grst (grst),
    .bus  (bus_if)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  task automatic wr(input logic [3:0] addr, input logic [2:0] data);
    bus_if.wr_en   = 1'b1;
    bus_if.wr_addr = addr;
    bus_if.wr_data = data;
    tick();
    bus_if.wr_en   = 1'b0;
  endtask

  task automatic launch(input logic [4:0] len, input logic [7:0] loops);
    bus_if.start = 1'b1;
    bus_if.len   = len;
    bus_if.loops = loops;
    tick();
    bus_if.start = 1'b0;
  endtask

  task automatic vec(input string tag, input logic [2:0] s);
    chk({tag, "_sig"},   32'(bus_if.sig), 32'(s));
    chk({tag, "_valid"}, 32'(bus_if.sig_valid), 32'd1);
  endtask

`ifdef SVA_STIM_LFSR_EN
  task automatic lfsr_run(input string tag);
    logic [15:0] m;
    logic        fb;
    m = 16'hACE1;
    bus_if.lfsr_mode = 1'b1;
    bus_if.seed      = 16'h0000;
    launch(5'd4, 8'd2);
    for (int i = 0; i < 8; i++) begin
      tick();
      vec($sformatf("%s_v%0d", tag, i), m[2:0]);
      fb = m[0] ^ m[2] ^ m[3] ^ m[5];
      m  = {fb, m[15:1]};
    end
    tick();
    chk({tag, "_done"}, 32'(bus_if.done), 32'd1);
    bus_if.lfsr_mode = 1'b0;
  endtask
`endif

  logic [2:0] pat [4];

  initial begin
    n_checks = 0;
    n_errors = 0;
    pat[0] = 3'd7; pat[1] = 3'd3; pat[2] = 3'd5; pat[3] = 3'd7;
    grst = 1'b1;
    bus_if.wr_en = 1'b0; bus_if.wr_addr = '0; bus_if.wr_data = '0;
    bus_if.start = 1'b0; bus_if.len = '0; bus_if.loops = '0;
    bus_if.pause = 1'b0; bus_if.stop = 1'b0;
`ifdef SVA_STIM_LFSR_EN
    bus_if.lfsr_mode = 1'b0; bus_if.seed = '0;
`endif

    // Reset state
    repeat (2) tick();
    chk("rst_sig", 32'(bus_if.sig), 32'd0);
    chk("rst_valid", 32'(bus_if.sig_valid), 32'd0);
    chk("rst_busy", 32'(bus_if.busy), 32'd0);
    chk("rst_done", 32'(bus_if.done), 32'd0);
    chk("rst_cfg_err", 32'(bus_if.cfg_err), 32'd0);
    chk("rst_loop_cnt", 32'(bus_if.loop_cnt), 32'd0);
    grst = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) wr(4'(i), pat[i]);

    // Single loop: 7,3,5,7 then done with busy falling
    launch(5'd4, 8'd1);
    chk("t1_busy_e0", 32'(bus_if.busy), 32'd1);
    chk("t1_valid_e0", 32'(bus_if.sig_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      vec($sformatf("t1_v%0d", i), pat[i]);
      chk($sformatf("t1_done_v%0d", i), 32'(bus_if.done), 32'd0);
    end
    tick();
    chk("t1_done", 32'(bus_if.done), 32'd1);
    chk("t1_valid_end", 32'(bus_if.sig_valid), 32'd0);
    chk("t1_sig_end", 32'(bus_if.sig), 32'd0);
    chk("t1_busy_end", 32'(bus_if.busy), 32'd0);
    chk("t1_loop_cnt", 32'(bus_if.loop_cnt), 32'd1);
    tick();
    chk("t1_done_pulse", 32'(bus_if.done), 32'd0);

    // Three loops: 12 vectors, loop_cnt 1,2,3, one done
    launch(5'd4, 8'd3);
    for (int i = 0; i < 12; i++) begin
      tick();
      vec($sformatf("t2_v%0d", i), pat[i % 4]);
      chk($sformatf("t2_lc%0d", i), 32'(bus_if.loop_cnt), 32'((i + 1) / 4));
      chk($sformatf("t2_nodone%0d", i), 32'(bus_if.done), 32'd0);
    end
    tick();
    chk("t2_done", 32'(bus_if.done), 32'd1);
    chk("t2_loop_cnt", 32'(bus_if.loop_cnt), 32'd3);
    tick();
    chk("t2_done_pulse", 32'(bus_if.done), 32'd0);

    // Infinite run with 3-cycle pause, start-while-busy, stop with pause
    launch(5'd4, 8'd0);
    tick(); vec("t3_v0", 3'd7);
    tick(); vec("t3_v1", 3'd3);
    bus_if.pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t3_p%0d_sig", i), 32'(bus_if.sig), 32'd3);
      chk($sformatf("t3_p%0d_valid", i), 32'(bus_if.sig_valid), 32'd0);
      chk($sformatf("t3_p%0d_busy", i), 32'(bus_if.busy), 32'd1);
    end
    bus_if.pause = 1'b0;
    tick(); vec("t3_v2", 3'd5);
    tick(); vec("t3_v3", 3'd7);
    chk("t3_loop_cnt", 32'(bus_if.loop_cnt), 32'd1);
    bus_if.start = 1'b1; bus_if.len = 5'd0;
    tick(); vec("t3_v4", 3'd7);
    chk("t3_busy_start_cfg", 32'(bus_if.cfg_err), 32'd0);
    bus_if.start = 1'b0;
    bus_if.stop = 1'b1; bus_if.pause = 1'b1;
    tick();
    chk("t3_stop_busy", 32'(bus_if.busy), 32'd0);
    chk("t3_stop_sig", 32'(bus_if.sig), 32'd0);
    chk("t3_stop_valid", 32'(bus_if.sig_valid), 32'd0);
    chk("t3_stop_done", 32'(bus_if.done), 32'd0);
    bus_if.stop = 1'b0; bus_if.pause = 1'b0;
    tick();
    chk("t3_stop_done2", 32'(bus_if.done), 32'd0);

    // Illegal lengths
    launch(5'd0, 8'd1);
    chk("t4_len0_cfg", 32'(bus_if.cfg_err), 32'd1);
    chk("t4_len0_busy", 32'(bus_if.busy), 32'd0);
    tick();
    chk("t4_len0_pulse", 32'(bus_if.cfg_err), 32'd0);
    launch(5'd17, 8'd1);
    chk("t4_len17_cfg", 32'(bus_if.cfg_err), 32'd1);
    chk("t4_len17_busy", 32'(bus_if.busy), 32'd0);
    tick();
    chk("t4_len17_pulse", 32'(bus_if.cfg_err), 32'd0);
    chk("t4_len17_busy2", 32'(bus_if.busy), 32'd0);

    // Async reset mid-loop, then replay from preserved RAM
    launch(5'd4, 8'd0);
    repeat (5) tick();
    chk("t5_pre_lc", 32'(bus_if.loop_cnt), 32'd1);
    chk("t5_pre_sig", 32'(bus_if.sig), 32'd7);
    grst = 1'b1;
    #1;
    chk("t5_rst_sig", 32'(bus_if.sig), 32'd0);
    chk("t5_rst_valid", 32'(bus_if.sig_valid), 32'd0);
    chk("t5_rst_busy", 32'(bus_if.busy), 32'd0);
    chk("t5_rst_lc", 32'(bus_if.loop_cnt), 32'd0);
    @(negedge gclk);
    grst = 1'b0;
    tick();
    launch(5'd2, 8'd1);
    tick(); vec("t5_v0", 3'd7);
    tick(); vec("t5_v1", 3'd3);
    tick();
    chk("t5_done", 32'(bus_if.done), 32'd1);
    chk("t5_busy", 32'(bus_if.busy), 32'd0);

    // len=1 boundary with read-before-write on the address being played
    launch(5'd1, 8'd2);
    bus_if.wr_en = 1'b1; bus_if.wr_addr = 4'd0; bus_if.wr_data = 3'd2;
    tick(); vec("t6_v0_old", 3'd7);
    bus_if.wr_en = 1'b0;
    chk("t6_lc1", 32'(bus_if.loop_cnt), 32'd1);
    tick(); vec("t6_v1_new", 3'd2);
    chk("t6_lc2", 32'(bus_if.loop_cnt), 32'd2);
    tick();
    chk("t6_done", 32'(bus_if.done), 32'd1);
    chk("t6_sig_end", 32'(bus_if.sig), 32'd0);

`ifdef SVA_STIM_LFSR_EN
    for (int i = 0; i < 4; i++) wr(4'(i), 3'd0);
    tick();
    lfsr_run("lf_a");
    tick();
    lfsr_run("lf_b");
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
